// File: rtl/hazard_ctrl.sv
// ============================================================================
//  Module      : hazard_ctrl
//  Description : Hazard controller for the five-stage RV32I pipeline.
//                Produces Execute-stage operand forwarding selects and the
//                stall/flush enables for the F/D/E/M pipeline registers.
//                Load-use stalls and taken-branch flushes are purely
//                combinational; multi-cycle data-memory waits are tracked by
//                a small FSM with a timeout watchdog that parks the core in
//                a sticky error state.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1_D,
  input  logic [4:0]       Rs2_D,
  input  logic [4:0]       Rs1_E,
  input  logic [4:0]       Rs2_E,
  input  logic [4:0]       RD_E,
  input  logic [4:0]       RD_M,
  input  logic [4:0]       RD_W,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             ResultSrc_E,
  input  logic             PCSrc_E,
  input  logic             mem_req_M,
  input  logic             mem_ack,
  output logic [1:0]       ForwardA_E,
  output logic [1:0]       ForwardB_E,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Stall_E,
  output logic             Stall_M,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  // Wait counter must be able to hold TIMEOUT-1; sized as ceil(log2(TIMEOUT+1)).
  localparam int                  c_WCNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [c_WCNT_W-1:0] c_WCNT_LAST = c_WCNT_W'(TIMEOUT - 1);
  localparam logic [c_WCNT_W-1:0] c_WCNT_ONE  = c_WCNT_W'(1);
  localparam logic [CNT_W-1:0]    c_CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERR      = 2'd2
  } state_t;

  state_t              r_state;
  logic [c_WCNT_W-1:0] r_wait_cnt;
  logic                r_mem_err;
  logic [CNT_W-1:0]    r_stall_cycles;
  logic [CNT_W-1:0]    r_flush_count;

  logic w_mw;
  logic w_lu;

  // Forward select for one source: M stage beats W stage, x0 never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       wr_m,
    input logic [4:0] rd_m,
    input logic       wr_w,
    input logic [4:0] rd_w
  );
    if (wr_m && (rd_m != 5'd0) && (rd_m == src)) begin
      return 2'b10;
    end else if (wr_w && (rd_w != 5'd0) && (rd_w == src)) begin
      return 2'b01;
    end else begin
      return 2'b00;
    end
  endfunction

  assign ForwardA_E = fwd_sel(Rs1_E, RegWrite_M, RD_M, RegWrite_W, RD_W);
  assign ForwardB_E = fwd_sel(Rs2_E, RegWrite_M, RD_M, RegWrite_W, RD_W);

  // Memory wait is visible in the very first cycle of an un-acked request,
  // so the stall does not depend on the FSM having entered MEM_WAIT yet.
  assign w_mw = mem_req_M & ~mem_ack;
  assign w_lu = ResultSrc_E & (RD_E != 5'd0) & ((RD_E == Rs1_D) | (RD_E == Rs2_D));

  // Stall/flush priority: error, memory wait, branch flush, load-use.
  always_comb begin
    Stall_F = 1'b0;
    Stall_D = 1'b0;
    Stall_E = 1'b0;
    Stall_M = 1'b0;
    Flush_D = 1'b0;
    Flush_E = 1'b0;
    if (rst) begin
      // Pipeline control is released while reset is held.
      Stall_F = 1'b0;
    end else if ((r_state == S_ERR) || w_mw) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Stall_E = 1'b1;
      Stall_M = 1'b1;
    end else if (PCSrc_E) begin
      // The flush kills any load-use dependent, so no stall is needed.
      Flush_D = 1'b1;
      Flush_E = 1'b1;
    end else if (w_lu) begin
      Stall_F = 1'b1;
      Stall_D = 1'b1;
      Flush_E = 1'b1;
    end
  end

  // Memory-wait FSM; wait_cnt counts the wait cycles completed before the current one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= '0;
      r_mem_err  <= 1'b0;
    end else begin
      unique case (r_state)
        S_RUN, S_MEM_WAIT: begin
          if (w_mw) begin
            if (r_wait_cnt == c_WCNT_LAST) begin
              r_state   <= S_ERR;
              r_mem_err <= 1'b1;
            end else begin
              r_state    <= S_MEM_WAIT;
              r_wait_cnt <= r_wait_cnt + c_WCNT_ONE;
            end
          end else begin
            // Ack (or a withdrawn request) releases the pipeline.
            r_state    <= S_RUN;
            r_wait_cnt <= '0;
          end
        end
        S_ERR: begin
          r_state   <= S_ERR;
          r_mem_err <= 1'b1;
        end
        default: begin
          r_state    <= S_RUN;
          r_wait_cnt <= '0;
          r_mem_err  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_err = r_mem_err;

  // Saturating performance counters, updated one cycle after the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (Stall_F && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + c_CNT_ONE;
      end
      if (Flush_D && (r_flush_count != '1)) begin
        r_flush_count <= r_flush_count + c_CNT_ONE;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;

endmodule

`default_nettype wire
